// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
// The inverse multipliers exist only when INV_MIX_COLUMNS_EN is defined.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef logic [AES_STATE_W-1:0] aes_state_t;
  typedef logic [AES_COL_W-1:0]   aes_col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return gf_xtime(x) ^ x;
  endfunction

`ifdef INV_MIX_COLUMNS_EN
  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return gf_xtime(gf_xtime(gf_xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] x);
    return gf_xtime(gf_xtime(gf_xtime(x))) ^ gf_xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] x);
    return gf_xtime(gf_xtime(gf_xtime(x))) ^ gf_xtime(gf_xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] x);
    return gf_xtime(gf_xtime(gf_xtime(x))) ^ gf_xtime(gf_xtime(x)) ^ gf_xtime(x);
  endfunction
`endif

endpackage

// File: rtl/mix_column_word.sv
// Combinational single-column (Inv)MixColumns with bypass.
// Inverse path is built only when INV_MIX_COLUMNS_EN is defined.
module mix_column_word
  import aes_pkg::*;
(
  input  aes_col_t i_col,
  input  logic     i_inverse,
  input  logic     i_bypass,
  output aes_col_t o_col
);

  logic [7:0] a [4];
  aes_col_t   fwd_col;
  aes_col_t   mix_col;

  // Row 0 is the most significant byte of the column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r] = i_col[31-8*r -: 8];
    end
  end

  always_comb begin
    fwd_col = '0;
    for (int r = 0; r < 4; r++) begin
      fwd_col[31-8*r -: 8] = gf_xtime(a[r]) ^ gf_mul3(a[(r+1)&3]) ^ a[(r+2)&3] ^ a[(r+3)&3];
    end
  end

`ifdef INV_MIX_COLUMNS_EN
  aes_col_t inv_col;

  always_comb begin
    inv_col = '0;
    for (int r = 0; r < 4; r++) begin
      inv_col[31-8*r -: 8] = gf_mul14(a[r]) ^ gf_mul11(a[(r+1)&3]) ^
                             gf_mul13(a[(r+2)&3]) ^ gf_mul9(a[(r+3)&3]);
    end
  end

  assign mix_col = i_inverse ? inv_col : fwd_col;
`else
  logic unused_inverse;
  assign unused_inverse = i_inverse;
  assign mix_col        = fwd_col;
`endif

  assign o_col = i_bypass ? i_col : mix_col;

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine, COLS_PER_CYCLE columns per beat, valid/ready both sides.
// Define INV_MIX_COLUMNS_EN to build the inverse transform.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [AES_STATE_W-1:0] i_state,
  input  logic                   i_inverse,
  input  logic                   i_bypass,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [AES_STATE_W-1:0] o_state,
  output logic                   o_busy
);

  localparam int BEATS = 4 / COLS_PER_CYCLE;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e  state_r;
  mc_state_e  state_next;
  logic [1:0] beat_r;
  aes_state_t work_r;
  aes_state_t work_next;
  logic       byp_r;
  logic       inv_use;
  logic       accept;
  logic       last_beat;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  aes_col_t   sel_col [COLS_PER_CYCLE];
  aes_col_t   new_col [COLS_PER_CYCLE];

`ifdef INV_MIX_COLUMNS_EN
  logic inv_r;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inv_r <= 1'b0;
    end else if (accept) begin
      inv_r <= i_inverse;
    end
  end

  assign inv_use = inv_r;
`else
  logic unused_inverse;
  assign unused_inverse = i_inverse;
  assign inv_use        = 1'b0;
`endif

  assign accept    = i_valid & o_ready;
  assign last_beat = (beat_r == 2'(BEATS - 1));

  // Column k occupies bits [127-32k -: 32], i.e. base offset (~k)*32
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_idx[j] = beat_r * 2'(COLS_PER_CYCLE) + 2'(j);
    assign sel_col[j] = work_r[{~col_idx[j], 5'd0} +: AES_COL_W];

    mix_column_word u_word (
      .i_col     (sel_col[j]),
      .i_inverse (inv_use),
      .i_bypass  (byp_r),
      .o_col     (new_col[j])
    );
  end

  always_comb begin
    work_next = work_r;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      work_next[{~col_idx[j], 5'd0} +: AES_COL_W] = new_col[j];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_PROC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_PROC: begin
        if (last_beat) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_PROC;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_next = ST_PROC;
        end else if (i_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      work_r <= '0;
      beat_r <= 2'd0;
      byp_r  <= 1'b0;
    end else if (accept) begin
      work_r <= i_state;
      beat_r <= 2'd0;
      byp_r  <= i_bypass;
    end else if (state_r == ST_PROC) begin
      work_r <= work_next;
      beat_r <= beat_r + 2'd1;
    end
  end

  assign o_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && i_ready);
  assign o_valid = (state_r == ST_DONE);
  assign o_busy  = (state_r == ST_PROC);
  assign o_state = work_r;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
// Honours INV_MIX_COLUMNS_EN when computing expected inverse results.
module tb_mix_columns_seq;

  localparam logic [127:0] VEC_P     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_F     = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B     = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] VEC_B_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  typedef struct {
    logic [127:0] val;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vin   [3];
  logic         ordy  [3];
  logic [127:0] sin   [3];
  logic         inv   [3];
  logic         byp   [3];
  logic         ovld  [3];
  logic         irdy  [3];
  logic [127:0] sout  [3];
  logic         obusy [3];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic iv, input logic bp);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (bp) return s;
    if (iv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[k], s[127 - 32*c - 8*((r+k)%4) -: 8]);
        end
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic eff_inv(input logic iv);
`ifdef INV_MIX_COLUMNS_EN
    return iv;
`else
    return 1'b0 & iv;
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout got=none want=event", name);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int NB  = 4 / CPC;

    exp_t q[$];
    int   last_acc = -1;

    mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (vin[g]),
      .o_ready   (ordy[g]),
      .i_state   (sin[g]),
      .i_inverse (inv[g]),
      .i_bypass  (byp[g]),
      .o_valid   (ovld[g]),
      .i_ready   (irdy[g]),
      .o_state   (sout[g]),
      .o_busy    (obusy[g])
    );

    // scoreboard: record accepted blocks, retire completed outputs
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (ovld[g] && irdy[g] && q.size() > 0) void'(q.pop_front());
        if (vin[g] && ordy[g])
          q.push_back('{val: mix_model(sin[g], eff_inv(inv[g]), byp[g]), acc: cyc});
      end
    end

    // compare every valid output cycle against the model
    always @(negedge clk) begin
      if (!rst && ovld[g]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpc%0d spurious_valid got=%h want=no_output", CPC, sout[g]);
        end else begin
          chk($sformatf("cpc%0d model_state", CPC), sout[g], q[0].val);
          if (q[0].acc != last_acc) begin
            chk($sformatf("cpc%0d latency", CPC), 128'(cyc - q[0].acc - 1), 128'(NB));
            last_acc = q[0].acc;
          end
        end
      end
    end
  end

  task automatic send(input int n, input logic [127:0] s, input logic iv, input logic bp,
                      output int acc_cyc);
    int t;
    t = 0;
    acc_cyc = -1;
    @(negedge clk);
    vin[n] = 1'b1; sin[n] = s; inv[n] = iv; byp[n] = bp;
    #1;
    while (!ordy[n] && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      fail_timeout($sformatf("send%0d", n));
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc - 1;
    end
    vin[n] = 1'b0; sin[n] = '0; inv[n] = 1'b0; byp[n] = 1'b0;
  endtask

  task automatic wait_valid(input int n);
    int t;
    t = 0;
    @(negedge clk);
    while (!ovld[n] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_timeout($sformatf("valid%0d", n));
  endtask

  initial begin
    int ta;
    int tb;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; sin[i] = '0; inv[i] = 1'b0; byp[i] = 1'b0; irdy[i] = 1'b1;
    end

    // pin the model with hand-computed values
    chk("gmul_57_83", 128'(gmul(8'h57, 8'h83)), 128'(8'hc1));
    chk("model_fwd", mix_model(VEC_P, 1'b0, 1'b0), VEC_F);
    chk("model_inv", mix_model(VEC_F, 1'b1, 1'b0), VEC_P);
    chk("model_fwd_b", mix_model(VEC_B, 1'b0, 1'b0), VEC_B_OUT);
    chk("model_byp", mix_model(VEC_B, 1'b0, 1'b1), VEC_B);

    repeat (3) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("rst_valid%0d", n), 128'(ovld[n]), 128'(1'b0));
      chk($sformatf("rst_busy%0d", n), 128'(obusy[n]), 128'(1'b0));
      chk($sformatf("rst_ready%0d", n), 128'(ordy[n]), 128'(1'b1));
      chk($sformatf("rst_state%0d", n), sout[n], 128'h0);
    end
    rst = 1'b0;

    for (int n = 0; n < 3; n++) begin
      send(n, VEC_P, 1'b0, 1'b0, ta);
      wait_valid(n);
      chk($sformatf("fwd%0d", n), sout[n], VEC_F);
`ifdef INV_MIX_COLUMNS_EN
      send(n, VEC_F, 1'b1, 1'b0, ta);
      wait_valid(n);
      chk($sformatf("inv%0d", n), sout[n], VEC_P);
`else
      send(n, VEC_P, 1'b1, 1'b0, ta);
      wait_valid(n);
      chk($sformatf("inv_ignored%0d", n), sout[n], VEC_F);
`endif
    end

    // bypass with downstream stalled
    irdy[0] = 1'b0;
    send(0, VEC_B, 1'b0, 1'b1, ta);
    wait_valid(0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_state", sout[0], VEC_B);
      chk("stall_ready", 128'(ordy[0]), 128'(1'b0));
      chk("stall_valid", 128'(ovld[0]), 128'(1'b1));
      @(negedge clk);
    end
    irdy[0] = 1'b1;
    @(negedge clk);

    // back-to-back streaming on the two-column engine
    send(1, VEC_P, 1'b0, 1'b0, ta);
    send(1, VEC_B, 1'b0, 1'b0, tb);
    chk("b2b_spacing", 128'(tb - ta), 128'(3));
    wait_valid(1);
    chk("b2b_second", sout[1], VEC_B_OUT);

    // reset during beat 1 of the single-column engine
    send(0, VEC_B, 1'b0, 1'b0, ta);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(ovld[0]), 128'(1'b0));
    chk("midrst_busy", 128'(obusy[0]), 128'(1'b0));
    chk("midrst_ready", 128'(ordy[0]), 128'(1'b1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(0, VEC_P, 1'b0, 1'b0, ta);
    wait_valid(0);
    chk("after_rst", sout[0], VEC_F);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential, parametrised AES MixColumns engine that processes COLS_PER_CYCLE 32-bit columns per clock.
- Supports forward and (optional) inverse MixColumns, plus a bypass for the final round.
- Valid/ready handshake on both sides, so it drops into the iterative round datapath of the encryption and decryption cores.
- Replaces the purely combinational mix stage where area matters more than single-cycle latency.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per processing cycle; legal values 1, 2, 4; any other value is an elaboration error.
- BEATS, 4/COLS_PER_CYCLE, derived localparam; number of processing cycles per block; not overridable.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input block valid.
- o_ready  out  1  engine can accept a block this cycle.
- i_state  in  128  input state. Column k sits at bits [127-32k : 96-32k]; row 0 is the most significant byte of each column.
- i_inverse  in  1  1 = InvMixColumns; sampled at acceptance.
- i_bypass  in  1  1 = pass state through unchanged, with the same latency; sampled at acceptance.
- o_valid  out  1  output block valid.
- i_ready  in  1  downstream accepts the output.
- o_state  out  128  transformed state, same layout as i_state.
- o_busy  out  1  high in the PROC state.

Behaviour:
- Reset: all outputs are 0 except o_ready. State is IDLE, beat counter is 0, internal state register is 0.
- o_ready is 1 in IDLE and in DONE when i_ready=1; it is 0 otherwise. o_ready is 1 during reset.
- Accept: occurs on a clock edge with i_valid & o_ready.
  - Load i_state into the working register.
  - Latch i_inverse and i_bypass.
  - Clear the beat counter and move to PROC.
- PROC: each cycle transforms columns [beat*COLS_PER_CYCLE +: COLS_PER_CYCLE] in place and increments the beat counter.
  - After beat BEATS-1, move to DONE.
  - A column is never transformed twice.
- DONE: o_valid=1 and o_state equals the working register.
  - o_state and o_valid are held stable while i_ready=0.
  - On i_valid & i_ready: accept the new block and go to PROC; the output handshake completes in the same cycle.
  - On i_ready alone: go to IDLE.
- Latency: o_valid rises BEATS cycles after the accept edge (4, 2 or 1 cycles). Throughput is one block per BEATS+1 cycles in back-to-back streaming.
- Arithmetic is in GF(2^8) with reduction polynomial 0x11B. xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0).
  - Forward row r: out_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - Inverse row r: out_r = 14·a_r ^ 11·a_(r+1) ^ 13·a_(r+2) ^ 9·a_(r+3).
- Bypass: runs the same state sequence but leaves the columns unmodified.
- Inputs are ignored while o_ready=0; i_state need not be held after acceptance.
- Reset mid-operation: immediately returns to IDLE and drops o_valid; the partially processed block is discarded.
- i_ready with o_valid=0 has no effect.

Optional Feature:
- INV_MIX_COLUMNS_EN
  - Defined: the inverse datapath is built and i_inverse is honoured.
  - Undefined: no inverse logic is generated; i_inverse is ignored and treated as 0; the port remains for interface stability.

Decomposition:
- Package aes_pkg holds:
  - AES_STATE_W=128, AES_COL_W=32.
  - The state/column typedefs.
  - Functions gf_xtime, gf_mul3, and (under the macro) gf_mul9/11/13/14.
- Sub-module mix_column_word: a combinational 32-bit single-column transform with inputs i_col, i_inverse, i_bypass and output o_col.
  - Instantiated COLS_PER_CYCLE times.
  - Columns are selected by a beat-indexed mux.

Test Plan:
- Forward, COLS_PER_CYCLE=1: i_state=128'hdb135345_f20a225c_01010101_c6c6c6c6 -> o_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6. o_valid rises 4 cycles after accept.
- Inverse (macro defined), all legal COLS_PER_CYCLE: i_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 with i_inverse=1 -> 128'hdb135345_f20a225c_01010101_c6c6c6c6. Latency is 4, 2 and 1 cycles respectively.
- Bypass plus backpressure: i_state=128'hd4d4d4d5_2d26314c_00000000_ffffffff, i_bypass=1, i_ready held 0 for 5 cycles -> output equals input. o_state is stable and o_ready=0 throughout the stall.
- Back-to-back, COLS_PER_CYCLE=2: the second block (128'hd4d4d4d5_2d26314c_…) is accepted in the same cycle the first is taken. Column results include d5d5d7d6 and 4d7ebdf8, and no idle cycle is inserted.
- Reset mid-PROC: assert i_rst at beat 1 -> o_valid=0, o_busy=0, o_ready=1 immediately. The next block produces a correct result with no residue from the aborted block.
- Macro undefined: i_inverse=1 on the vector from the first scenario -> the forward result 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6.
